// File: rtl/spi_pkg.sv
// Shared definitions for the 12-bit SPI transmit link.
package spi_pkg;

  // Frame width fixed by the receive side of the link.
  localparam int SPI_DATA_W = 12;

  // Transmit sequencer states.
  typedef enum logic [1:0] {
    FLUSH = 2'd0,
    IDLE  = 2'd1,
    SHIFT = 2'd2
  } spi_state_e;

endpackage : spi_pkg

// File: rtl/spi_sclk_gen.sv
// Free-running SPI clock generator. sclk toggles every CLK_DIV clk cycles.
// fall_evt / rise_evt are high in the clk cycle whose closing edge makes
// sclk fall / rise, so logic clocked on that same edge changes together
// with sclk.
module spi_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic sclk,
  output logic fall_evt,
  output logic rise_evt
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] div_cnt_r;
  logic [CNT_W-1:0] div_cnt_next_s;
  logic             sclk_r;
  logic             sclk_next_s;
  logic             toggle_s;

  // Divider next-state: wrap the counter and flip sclk at the terminal count.
  always_comb begin
    toggle_s       = (div_cnt_r == CNT_MAX);
    div_cnt_next_s = div_cnt_r;
    sclk_next_s    = sclk_r;
    if (toggle_s) begin
      div_cnt_next_s = '0;
      sclk_next_s    = ~sclk_r;
    end else begin
      div_cnt_next_s = div_cnt_r + CNT_W'(1);
      sclk_next_s    = sclk_r;
    end
  end

  // Divider and sclk registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_r <= '0;
      sclk_r    <= 1'b0;
    end else begin
      div_cnt_r <= div_cnt_next_s;
      sclk_r    <= sclk_next_s;
    end
  end

  assign sclk     = sclk_r;
  assign fall_evt = toggle_s & sclk_r;
  assign rise_evt = toggle_s & ~sclk_r;

endmodule : spi_sclk_gen

// File: rtl/spi_master.sv
// Transmit end of the 12-bit SPI link: valid/ready input with a single
// holding register, LSB-first shifting on mosi, cs framing, and a flush
// period after reset that lets a receiver left mid-frame run out.
module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_W  = SPI_DATA_W,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              cs,
  output logic              mosi
);

  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam int FL_W  = $clog2(DATA_W + 2);
  // Stop condition: all DATA_W bits have been presented.
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_W);
  // Last of the DATA_W+2 flush fall events.
  localparam logic [FL_W-1:0]  FLUSH_LAST = FL_W'(DATA_W + 1);

  spi_state_e        state_r,      state_next_s;
  logic [DATA_W-1:0] hold_r,       hold_next_s;
  logic              hold_full_r,  hold_full_next_s;
  logic [DATA_W-1:0] shreg_r,      shreg_next_s;
  logic [BIT_W-1:0]  bitcnt_r,     bitcnt_next_s;
  logic [FL_W-1:0]   flush_cnt_r,  flush_cnt_next_s;
  logic              cs_r,         cs_next_s;
  logic              mosi_r,       mosi_next_s;
  logic              done_r,       done_next_s;
  logic              din_ready_r,  din_ready_next_s;
  logic              busy_r,       busy_next_s;
  logic              accept_s;
  logic              fall_evt_s;
  // The rise strobe is exposed by the generator for receive-side reuse;
  // the transmitter only acts on falling edges.
  logic              unused_rise_evt_s;

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk      (clk),
    .rst      (rst),
    .sclk     (sclk),
    .fall_evt (fall_evt_s),
    .rise_evt (unused_rise_evt_s)
  );

  // Next-state, holding-register and output decode for the sequencer.
  always_comb begin
    state_next_s     = state_r;
    hold_next_s      = hold_r;
    hold_full_next_s = hold_full_r;
    shreg_next_s     = shreg_r;
    bitcnt_next_s    = bitcnt_r;
    flush_cnt_next_s = flush_cnt_r;
    cs_next_s        = cs_r;
    mosi_next_s      = mosi_r;
    done_next_s      = 1'b0;

    // din_ready_r already encodes "holding register empty and not flushing",
    // so an accept can never coincide with a drain below.
    accept_s = din_valid & din_ready_r;
    if (accept_s) begin
      hold_next_s      = din;
      hold_full_next_s = 1'b1;
    end else begin
      hold_next_s      = hold_r;
      hold_full_next_s = hold_full_r;
    end

    case (state_r)
      FLUSH: begin
        if (fall_evt_s) begin
          if (flush_cnt_r == FLUSH_LAST) begin
            flush_cnt_next_s = '0;
            state_next_s     = IDLE;
          end else begin
            flush_cnt_next_s = flush_cnt_r + FL_W'(1);
          end
        end else begin
          flush_cnt_next_s = flush_cnt_r;
        end
      end
      IDLE: begin
        if (fall_evt_s && hold_full_r) begin
          shreg_next_s     = hold_r;
          hold_full_next_s = 1'b0;
          bitcnt_next_s    = '0;
          cs_next_s        = 1'b0;
          mosi_next_s      = hold_r[0];
          state_next_s     = SHIFT;
        end else begin
          state_next_s = IDLE;
        end
      end
      SHIFT: begin
        if (fall_evt_s) begin
          if (bitcnt_r == BIT_LAST) begin
            cs_next_s    = 1'b1;
            mosi_next_s  = 1'b0;
            done_next_s  = 1'b1;
            state_next_s = IDLE;
          end else begin
            mosi_next_s   = shreg_r[bitcnt_r];
            bitcnt_next_s = bitcnt_r + BIT_W'(1);
          end
        end else begin
          state_next_s = SHIFT;
        end
      end
      default: begin
        state_next_s = FLUSH;
      end
    endcase

    din_ready_next_s = ~hold_full_next_s & (state_next_s != FLUSH);
    busy_next_s      = (state_next_s == SHIFT) | hold_full_next_s;
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= FLUSH;
      hold_r      <= '0;
      hold_full_r <= 1'b0;
      shreg_r     <= '0;
      bitcnt_r    <= '0;
      flush_cnt_r <= '0;
      cs_r        <= 1'b1;
      mosi_r      <= 1'b0;
      done_r      <= 1'b0;
      din_ready_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      hold_r      <= hold_next_s;
      hold_full_r <= hold_full_next_s;
      shreg_r     <= shreg_next_s;
      bitcnt_r    <= bitcnt_next_s;
      flush_cnt_r <= flush_cnt_next_s;
      cs_r        <= cs_next_s;
      mosi_r      <= mosi_next_s;
      done_r      <= done_next_s;
      din_ready_r <= din_ready_next_s;
      busy_r      <= busy_next_s;
    end
  end

  assign din_ready = din_ready_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign cs        = cs_r;
  assign mosi      = mosi_r;

endmodule : spi_master

// File: doc/spi_master.md
Name: spi_master

Overview:
- Transmit end of the 12-bit SPI link. Derives a free-running sclk from the system clock and frames words with active-low cs.
- Shifts data out on mosi LSB first, so the existing receive-side SPI block (samples on sclk rising edge) captures it unmodified.
- Takes words from upstream logic over a valid/ready handshake, with one holding register so that frames can run back to back.

Parameters:
- DATA_W, 12: frame width in bits. Must match the receiver; the receiver is fixed at 12.
- CLK_DIV, 4: sclk half-period in clk cycles. Must be >= 1.

Ports:
- clk  input  1  system clock, rising edge only
- rst  input  1  synchronous reset, active-high
- din  input  DATA_W  word to transmit
- din_valid  input  1  din is valid
- din_ready  output  1  block accepts din this cycle
- busy  output  1  frame in progress or word held
- done  output  1  one-clk pulse at end of each frame
- sclk  output  1  SPI clock, free-running after reset
- cs  output  1  chip select, active-low
- mosi  output  1  serial data, LSB first

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset rst is synchronous and active-high.
  - All outputs registered.
- Reset values: sclk=0, cs=1, mosi=0, done=0, din_ready=0, busy=0; holding register empty; state FLUSH; divider and bit counters 0.
- Divider:
  - Counter runs 0..CLK_DIV-1. When it reaches CLK_DIV-1, sclk toggles and the counter returns to 0.
  - fall_evt = the clk cycle in which sclk toggles 1->0. cs and mosi update only on fall_evt, in the same clk edge as sclk falls.
  - The receiver samples at sclk rise, half a period later.
- Handshake:
  - din_ready = holding register empty AND state != FLUSH.
  - Transfer occurs when din_valid & din_ready. din is captured into the holding register and din_ready drops the next cycle.
  - din is not sampled when din_ready=0. There is no drop and no duplication.
- busy = (state==SHIFT) OR holding register full.
- States:
  - FLUSH: cs=1 for DATA_W+2 fall_evts after reset, then IDLE. This guarantees a receiver left mid-frame runs out and returns to start-detect. The receiver may emit one spurious done during FLUSH; this is tolerated.
  - IDLE: on fall_evt with holding register full, the following happen together and the state moves to SHIFT:
    - load the shift register;
    - empty the holding register;
    - bitcnt<=0, cs<=0, mosi<=bit 0.
  - SHIFT, on each fall_evt:
    - If bitcnt<DATA_W: mosi<=shreg[bitcnt], bitcnt<=bitcnt+1.
    - If bitcnt==DATA_W: cs<=1, mosi<=0, done=1 for one clk, state IDLE.
- Frame timing:
  - cs is low for exactly DATA_W+1 sclk periods: one start-detect rise plus DATA_W data rises.
  - Data bit k is stable across the (k+2)-th sclk rise after cs falls.
- Gaps and latency:
  - Minimum inter-frame gap is cs high for exactly one sclk period, when the next word is already held.
  - Latency from accept to cs fall: up to 2*CLK_DIV clk in IDLE (waits for the next fall_evt).
- Simultaneous events:
  - A new word may be accepted during SHIFT. It is held and starts at the fall_evt after the stop.
  - The drain of the holding register and a new accept never happen in the same cycle, because din_ready is 0 while the register is full.
- rst mid-frame: all outputs go to reset values at the next clk edge and the block re-enters FLUSH. The partial word is discarded with no done.

Decomposition:
- Shared package spi_pkg: state enum (FLUSH, IDLE, SHIFT) and localparam SPI_DATA_W=12.
- One natural sub-module, spi_sclk_gen (parameter CLK_DIV). It outputs sclk and the fall_evt/rise_evt strobes, with the same synchronous reset.

Test Plan:
- Post-reset: rst 3 clk then release -> cs=1 and din_ready=0 for 14 fall_evts, then din_ready=1; sclk period 2*CLK_DIV clk throughout.
- Single frame: din=12'hA5C -> mosi bits at receiver sample points 0,0,1,1,1,0,1,0,0,1,0,1; receiver dout=12'hA5C with its done pulse; master done one clk; cs low 13 sclk periods.
- Back-to-back: din_valid held with 12'h001 then 12'hFFF -> second word accepted during first frame; cs high exactly 1 sclk period between frames; receiver captures 12'h001 then 12'hFFF.
- Backpressure: din_valid held with changing din while din_ready=0 -> only words present on accept cycles are transmitted, each exactly once.
- Reset mid-frame: rst after 5th data bit -> next clk cs=1, sclk=0, done never pulses; after FLUSH, din=12'h3C3 is received correctly.
- CLK_DIV=1: din=12'h800 -> sclk toggles every clk; receiver dout=12'h800; done pulses once.
